// File: rtl/alu_share_arbiter_if.sv
// Bundles the requester, response and ALU-facing signals of alu_share_arbiter.
// The slave modport is the arbiter; master is the issue logic plus the ALU.
interface alu_share_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ*4-1:0]     req_sel;
  logic [WIDTH-1:0]      alu_a;
  logic [WIDTH-1:0]      alu_b;
  logic [3:0]            alu_sel;
  logic [WIDTH-1:0]      alu_out;
  logic                  alu_overflow;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_overflow;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, req_sel, alu_out, alu_overflow,
    input  req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data,
           rsp_overflow, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, alu_out, alu_overflow,
    output req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data,
           rsp_overflow, rsp_err, busy
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one registered ALU between NREQ requesters.
// One operation in flight at a time; results come back as a one-cycle pulse.
module alu_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  alu_share_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(ALU_LAT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state_q, state_d;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_err_q, rsp_err_d;

  logic             found;
  logic [PTR_W-1:0] win, cand;
  logic [WIDTH-1:0] win_a, win_b;
  logic [3:0]       win_sel;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ-1:0]  rsp_valid;

  // Search starts at rr_ptr and wraps, so the last winner drops to lowest priority.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    cand    = '0;
    win_a   = '0;
    win_b   = '0;
    win_sel = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win == PTR_W'(i)) begin
        win_a   = bus.req_a[i*WIDTH +: WIDTH];
        win_b   = bus.req_b[i*WIDTH +: WIDTH];
        win_sel = bus.req_sel[i*4 +: 4];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_sel_d  = alu_sel_q;
    rsp_data_d = rsp_data_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          owner_d        = win;
          rr_ptr_d       = (win == PTR_LAST) ? '0 : win + 1'b1;
          if (win_sel <= 4'd4) begin
            alu_a_d   = win_a;
            alu_b_d   = win_b;
            alu_sel_d = win_sel;
            cnt_d     = '0;
            state_d   = EXEC;
          end else begin
            // Illegal select never reaches the ALU; answer straight away.
            rsp_data_d = '0;
            rsp_ovf_d  = 1'b0;
            rsp_err_d  = 1'b1;
            state_d    = RESP;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          rsp_data_d = bus.alu_out;
          rsp_ovf_d  = bus.alu_overflow && (alu_sel_q >= 4'd3);
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = (state_q == RESP) && (owner_q == PTR_W'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_sel_q  <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_sel_q  <= alu_sel_d;
      rsp_data_q <= rsp_data_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign bus.req_ready    = req_ready;
  assign bus.rsp_valid    = rsp_valid;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_sel      = alu_sel_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_overflow = rsp_ovf_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.busy         = (state_q != IDLE);
endmodule
